// File: rtl/result_writer_pkg.sv
// result_writer_pkg: shared word width, counter width and FSM state encoding
package result_writer_pkg;
  localparam int WIDTH_DEF = 21;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;
endpackage

// File: rtl/result_writer_sync_fifo.sv
// sync_fifo: show-ahead FIFO with wrap-bit pointers; head reads as zero when empty
module sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  assign empty = wr_q == rd_q;
  assign full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];
  // pointer advance; reset discards contents by equalising pointers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop) rd_q <= rd_q + (AW+1)'(1);
    end
  // storage needs no reset
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/result_writer.sv
// result_writer: collects accelerator results into a FIFO and signals when a run is drained
module result_writer
  import result_writer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrReq,
  input  logic [WIDTH-1:0] wrData,
  input  logic             wDone,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData,
  output logic             runDone,
  output logic [CNT_W-1:0] termCount,
  output logic             overflow
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic full, empty, push, pop, collect;
  assign collect = state_q == IDLE || state_q == COLLECT;
  assign pop = outValid && outReady;
  assign push = wrReq && collect && (!full || pop);
  assign outValid = !empty;
  assign runDone = state_q == DONE;
  assign termCount = cnt_q;
  assign overflow = ovf_q;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(wrData),
    .full(full), .empty(empty), .rdata(outData)
  );
  // next state, word counter (dropped words in a run still count) and sticky drop flag
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | (wrReq & ~push);
    case (state_q)
      IDLE:
        if (wrReq) begin
          cnt_d = CNT_W'(1);
          state_d = wDone ? DRAIN : COLLECT;
        end else if (wDone) begin
          cnt_d = '0;
          state_d = DRAIN;
        end
      COLLECT: begin
        if (wrReq && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (wDone) state_d = DRAIN;
      end
      DRAIN: if (empty) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, counter and flag registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: randomized and directed scoreboard bench for result_writer
module tb_result_writer;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, wrReq = 0, wDone = 0, outReady = 0;
  logic [20:0] wrData = '0;
  logic outValid, runDone, overflow;
  logic [20:0] outData;
  logic [7:0] termCount;
  int ntests = 0, nfail = 0, ndone = 0;
  logic [20:0] q[$];
  int occ = 0, cnt = 0;
  bit ovf = 0, busy = 0, draining = 0, done_p = 0;

  result_writer dut (
    .clk(clk), .rst(rst), .wrReq(wrReq), .wrData(wrData), .wDone(wDone),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .runDone(runDone), .termCount(termCount), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    occ = 0; cnt = 0; ovf = 0; busy = 0; draining = 0; done_p = 0;
  endtask

  task automatic model(input bit wr, input logic [20:0] d, input bit dn, input bit rdy);
    bit acc, pop, fin;
    acc = !draining && !done_p;
    pop = occ > 0 && rdy;
    fin = draining && occ == 0;
    done_p = 0;
    if (fin) begin draining = 0; done_p = 1; end
    if (wr) begin
      if (acc) begin
        if (!busy) begin cnt = 1; busy = 1; end
        else if (cnt < 255) cnt++;
      end
      if (acc && (occ < DEPTH || pop)) begin q.push_back(d); occ++; end
      else ovf = 1;
    end
    if (pop) occ--;
    if (dn && acc) begin
      if (!busy) cnt = 0;
      busy = 0;
      draining = 1;
    end
  endtask

  task automatic step(input bit wr, input logic [20:0] d, input bit dn, input bit rdy);
    wrReq = wr; wrData = d; wDone = dn; outReady = rdy;
    @(posedge clk);
    model(wr, d, dn, rdy);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, 1);
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_valid", outValid, 0);
    chk("rst_data", outData, 0);
    chk("rst_done", runDone, 0);
    chk("rst_count", termCount, 0);
    chk("rst_ovf", overflow, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1;
  endtask

  always @(negedge clk)
    if (rst) begin
      chk("valid", outValid, occ > 0);
      chk("run_done", runDone, done_p);
      chk("term_count", termCount, cnt);
      chk("overflow", overflow, ovf);
      if (outValid) begin
        if (q.size() == 0) chk("data_unexpected", outData, 0);
        else begin
          chk("data", outData, q[0]);
          if (outReady) void'(q.pop_front());
        end
      end
      if (runDone) ndone++;
    end

  initial begin
    int d0;
    #1 rst = 0;
    #1;
    chk("init_valid", outValid, 0);
    chk("init_data", outData, 0);
    chk("init_count", termCount, 0);
    chk("init_ovf", overflow, 0);
    chk("init_done", runDone, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    idle(2);

    d0 = ndone;
    step(1, 21'h00001, 0, 1);
    step(1, 21'h1FFFFF, 0, 1);
    step(1, 21'h0ABCD, 0, 1);
    step(0, '0, 1, 1);
    idle(6);
    chk("t1_count", termCount, 3);
    chk("t1_runs", ndone - d0, 1);

    d0 = ndone;
    for (int i = 0; i < 9; i++) step(1, 21'(32'h1000 + i), 0, 0);
    chk("t2_ovf", overflow, 1);
    chk("t2_count", termCount, 9);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    idle(14);
    chk("t2_runs", ndone - d0, 1);
    chk("t2_drained", q.size(), 0);

    do_reset();
    idle(1);
    d0 = ndone;
    for (int i = 0; i < 8; i++) step(1, 21'(32'h2000 + i), 0, 0);
    step(1, 21'h0DEAD, 0, 1);
    chk("t3_ovf", overflow, 0);
    step(0, '0, 1, 1);
    idle(14);
    chk("t3_ovf_end", overflow, 0);
    chk("t3_count", termCount, 9);
    chk("t3_runs", ndone - d0, 1);

    d0 = ndone;
    step(0, '0, 1, 1);
    idle(4);
    chk("t4_count", termCount, 0);
    chk("t4_runs", ndone - d0, 1);

    d0 = ndone;
    step(1, 21'h0F00F, 0, 1);
    step(1, 21'h100000, 1, 1);
    idle(6);
    chk("t5_count", termCount, 2);
    chk("t5_runs", ndone - d0, 1);

    d0 = ndone;
    for (int i = 0; i < 4; i++) step(1, 21'(32'h3000 + i), 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    do_reset();
    idle(6);
    chk("t6_runs", ndone - d0, 0);

    for (int i = 0; i < 300; i++) step(1, 21'($urandom), 0, 1);
    chk("sat_count", termCount, 255);
    step(0, '0, 1, 1);
    idle(6);

    do_reset();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1), 21'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    step(0, '0, 1, 1);
    idle(20);
    chk("rand_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
